kmeans_centroid_update: RTL

- Downstream stage of the k-means distance/assign core (`kmeans`). It consumes each point together with its assigned nearest-cluster index.
- Per epoch it accumulates per-cluster coordinate sums and counts. On epoch end it computes new centroids as floor(sum/count) with a shared sequential divider.
- Four centroid registers (K=4, matching the 2-bit cluster index) are held and exposed through a select port. These feed the next epoch's distance calculation.

---
 rtl/kmeans_centroid_update.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/kmeans_centroid_update.sv
`default_nettype none
// ============================================================================
// Module      : kmeans_centroid_update
// Description : Per-epoch cluster sum/count accumulation and centroid update
//               through one shared restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
module kmeans_centroid_update #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_we,
    input  logic [1:0]        init_idx,
    input  logic [DATA_W-1:0] init_x,
    input  logic [DATA_W-1:0] init_y,
    input  logic              pt_valid,
    output logic              pt_ready,
    input  logic [DATA_W-1:0] pt_x,
    input  logic [DATA_W-1:0] pt_y,
    input  logic [1:0]        pt_idx,
    input  logic              epoch_end,
    input  logic [1:0]        sel,
    output logic [DATA_W-1:0] cx_o,
    output logic [DATA_W-1:0] cy_o,
    output logic              upd_busy,
    output logic              upd_done,
    output logic              changed,
    output logic              cnt_ovf
);

    localparam int c_SUM_W  = DATA_W + CNT_W;
    localparam int c_ITER_W = $clog2(c_SUM_W + 1);

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_DIV = 2'd1,
        ST_FIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [c_SUM_W-1:0]  r_sum_x [4];
    logic [c_SUM_W-1:0]  r_sum_y [4];
    logic [CNT_W-1:0]    r_cnt   [4];
    logic [DATA_W-1:0]   r_cx    [4];
    logic [DATA_W-1:0]   r_cy    [4];

    logic [1:0]          r_cl;
    logic                r_axis;
    logic                r_run;
    logic [c_ITER_W-1:0] r_iter;
    logic [c_SUM_W-1:0]  r_quo;
    logic [CNT_W-1:0]    r_rem;
    logic                r_changed;
    logic                r_ovf;

    logic                w_accept;
    logic                w_cnt_full;
    logic [CNT_W-1:0]    w_div_cnt;
    logic [c_SUM_W-1:0]  w_div_sum;
    logic [DATA_W-1:0]   w_old;
    logic [CNT_W:0]      w_shift;
    logic                w_ge;
    logic [c_SUM_W-1:0]  w_quo_next;
    logic [CNT_W-1:0]    w_rem_next;
    logic                w_last_iter;
    logic                w_empty;
    logic                w_axis_done;
    logic [DATA_W-1:0]   w_new;

    assign w_accept    = (r_state == ST_ACC) && pt_valid;
    assign w_cnt_full  = &r_cnt[pt_idx];
    assign w_div_cnt   = r_cnt[r_cl];
    assign w_div_sum   = r_axis ? r_sum_y[r_cl] : r_sum_x[r_cl];
    assign w_old       = r_axis ? r_cy[r_cl] : r_cx[r_cl];

    // Restoring step: remainder stays below the divisor, so the CNT_W-bit
    // subtraction result is exact.
    assign w_shift     = {r_rem, r_quo[c_SUM_W-1]};
    assign w_ge        = (w_shift >= {1'b0, w_div_cnt});
    assign w_quo_next  = {r_quo[c_SUM_W-2:0], w_ge};
    assign w_rem_next  = w_ge ? (w_shift[CNT_W-1:0] - w_div_cnt) : w_shift[CNT_W-1:0];
    assign w_new       = w_quo_next[DATA_W-1:0];

    assign w_last_iter = r_run && (r_iter == c_ITER_W'(c_SUM_W - 1));
    assign w_empty     = (w_div_cnt == '0);
    assign w_axis_done = (r_state == ST_DIV) && (r_run ? w_last_iter : w_empty);

    assign cx_o        = r_cx[sel];
    assign cy_o        = r_cy[sel];
    assign changed     = r_changed;
    assign cnt_ovf     = r_ovf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        pt_ready     = 1'b0;
        upd_busy     = 1'b0;
        upd_done     = 1'b0;
        case (r_state)
            ST_ACC: begin
                pt_ready = 1'b1;
                if (epoch_end) begin
                    w_state_next = ST_DIV;
                end
            end
            ST_DIV: begin
                upd_busy = 1'b1;
                if (w_axis_done && r_axis && (r_cl == 2'd3)) begin
                    w_state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                upd_busy     = 1'b1;
                upd_done     = 1'b1;
                w_state_next = ST_ACC;
            end
            default: begin
                w_state_next = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                r_sum_x[i] <= '0;
                r_sum_y[i] <= '0;
                r_cnt[i]   <= '0;
                r_cx[i]    <= '0;
                r_cy[i]    <= '0;
            end
            r_cl      <= 2'd0;
            r_axis    <= 1'b0;
            r_run     <= 1'b0;
            r_iter    <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_changed <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_accept) begin
                        if (w_cnt_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_sum_x[pt_idx] <= r_sum_x[pt_idx] + c_SUM_W'(pt_x);
                            r_sum_y[pt_idx] <= r_sum_y[pt_idx] + c_SUM_W'(pt_y);
                            r_cnt[pt_idx]   <= r_cnt[pt_idx] + CNT_W'(1);
                        end
                    end
                    if (init_we) begin
                        r_cx[init_idx] <= init_x;
                        r_cy[init_idx] <= init_y;
                    end
                    if (epoch_end) begin
                        r_changed <= 1'b0;
                        r_cl      <= 2'd0;
                        r_axis    <= 1'b0;
                        r_run     <= 1'b0;
                    end
                end
                ST_DIV: begin
                    if (!r_run) begin
                        if (!w_empty) begin
                            r_quo  <= w_div_sum;
                            r_rem  <= '0;
                            r_iter <= '0;
                            r_run  <= 1'b1;
                        end
                    end else begin
                        r_quo  <= w_quo_next;
                        r_rem  <= w_rem_next;
                        r_iter <= r_iter + c_ITER_W'(1);
                        if (w_last_iter) begin
                            r_run <= 1'b0;
                            if (r_axis) begin
                                r_cy[r_cl] <= w_new;
                            end else begin
                                r_cx[r_cl] <= w_new;
                            end
                            if (w_new != w_old) begin
                                r_changed <= 1'b1;
                            end
                        end
                    end
                    if (w_axis_done) begin
                        r_axis <= ~r_axis;
                        if (r_axis) begin
                            r_cl <= r_cl + 2'd1;
                        end
                    end
                end
                ST_FIN: begin
                    for (int i = 0; i < 4; i++) begin
                        r_sum_x[i] <= '0;
                        r_sum_y[i] <= '0;
                        r_cnt[i]   <= '0;
                    end
                    r_ovf <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
